// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame geometry,
// error-event indices and the odd-parity helper.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = FRAME_BITS - 3;

  localparam int EV_PARITY   = 0;
  localparam int EV_FRAME    = 1;
  localparam int EV_TIMEOUT  = 2;
  localparam int EV_OVERFLOW = 3;
  localparam int EV_NUM      = 4;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// CPU-side read/status bus of the PS/2 receiver; slave = receiver, master = reader.
interface ps2_rx_fifo_if #(parameter int CNT_W = 8);

  logic             rd;
  logic             err_clr;
  logic [7:0]       rd_data;
  logic             rd_err;
  logic             data_present;
  logic             data_half;
  logic             data_full;
  logic             err_parity;
  logic             err_frame;
  logic             err_timeout;
  logic             err_overflow;
  logic [CNT_W-1:0] err_count;

  modport master (
    output rd, err_clr,
    input  rd_data, rd_err, data_present, data_half, data_full,
    input  err_parity, err_frame, err_timeout, err_overflow, err_count
  );

  modport slave (
    input  rd, err_clr,
    output rd_data, rd_err, data_present, data_half, data_full,
    output err_parity, err_frame, err_timeout, err_overflow, err_count
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser followed by a stability filter: the output follows the
// synchronised line only after FILT_LEN consecutive differing samples.
module ps2_sync_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_r;
  logic          sync2_r;
  logic          filt_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, then count how long the line has disagreed with the filtered value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      filt_r  <= 1'b1;
      cnt_r   <= '0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r == filt_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CW'(FILT_LEN - 1)) begin
        filt_r <= sync2_r;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign dout = filt_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a first-word-fall-through receive FIFO.
// Optional macro PS2_RX_ERR_STORE_EN stores errored frames tagged via rd_err.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 20000,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_RX_ERR_STORE_EN
  localparam int EW = 9;
`else
  localparam int EW = 8;
`endif

  logic              clk_f_s, dat_f_s, clk_f_d_r, fall_s, timeout_s;
  logic [1:0]        state_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              par_ok_r;
  logic [TW-1:0]     timer_r;
  logic              push_r;
  logic [EW-1:0]     push_data_r;
  logic [EV_NUM-1:0] ev_s;
  logic [EV_NUM-1:0] flags_r;
  logic [CNT_W-1:0]  err_count_r;
  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     head_s;
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r, count_s, next_count_s;
  logic              full_s, empty_s, do_rd_s, do_wr_s;
  logic              present_r, half_r, full_r;

  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (.clk(clk), .rst(rst), .din(ps2_clk), .dout(clk_f_s));
  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (.clk(clk), .rst(rst), .din(ps2_dat), .dout(dat_f_s));

  assign fall_s    = clk_f_d_r & ~clk_f_s;
  assign timeout_s = (state_r != ST_IDLE) && !fall_s && (timer_r >= TW'(TIMEOUT_CYC - 1));

  // Frame deserialiser and inter-edge timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_f_d_r   <= 1'b1;
      state_r     <= ST_IDLE;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      par_ok_r    <= 1'b0;
      timer_r     <= '0;
      push_r      <= 1'b0;
      push_data_r <= '0;
    end else begin
      clk_f_d_r <= clk_f_s;
      push_r    <= 1'b0;
      if (fall_s) begin
        timer_r <= '0;
        case (state_r)
          ST_IDLE: begin
            if (!dat_f_s) begin
              state_r   <= ST_DATA;
              bit_idx_r <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_r   <= {dat_f_s, shift_r[7:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'(DATA_BITS - 1)) begin
              state_r <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_ok_r <= odd_parity_ok(shift_r, dat_f_s);
            state_r  <= ST_STOP;
          end
          ST_STOP: begin
            state_r <= ST_IDLE;
`ifdef PS2_RX_ERR_STORE_EN
            push_r      <= 1'b1;
            push_data_r <= {~(par_ok_r & dat_f_s), shift_r};
`else
            push_r      <= par_ok_r & dat_f_s;
            push_data_r <= shift_r;
`endif
          end
          default: state_r <= ST_IDLE;
        endcase
      end else if (timeout_s) begin
        state_r <= ST_IDLE;
        timer_r <= '0;
      end else if (state_r != ST_IDLE) begin
        timer_r <= timer_r + TW'(1);
      end else begin
        timer_r <= '0;
      end
    end
  end

  // Error events of the current cycle; a frame with bad parity and stop is one event.
  always_comb begin
    ev_s = '0;
    if (fall_s) begin
      case (state_r)
        ST_IDLE: ev_s[EV_FRAME] = dat_f_s;
        ST_STOP: begin
          ev_s[EV_PARITY] = ~par_ok_r;
          ev_s[EV_FRAME]  = ~dat_f_s;
        end
        default: ev_s = '0;
      endcase
    end else if (timeout_s) begin
      ev_s[EV_TIMEOUT] = 1'b1;
    end else begin
      ev_s[EV_TIMEOUT] = 1'b0;
    end
    ev_s[EV_OVERFLOW] = push_r & full_s & ~bus.rd;
  end

  // Sticky flags and saturating event counter; clear wins over a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r     <= '0;
      err_count_r <= '0;
    end else if (bus.err_clr) begin
      flags_r     <= '0;
      err_count_r <= '0;
    end else begin
      flags_r <= flags_r | ev_s;
      if ((|ev_s) && (err_count_r != '1)) begin
        err_count_r <= err_count_r + CNT_W'(1);
      end
    end
  end

  assign count_s = wr_ptr_r - rd_ptr_r;
  assign full_s  = (count_s == PW'(DEPTH));
  assign empty_s = (count_s == '0);
  assign do_rd_s = bus.rd & ~empty_s;
  assign do_wr_s = push_r & (~full_s | do_rd_s);

  // Occupancy after this cycle's push/pop, used to register the level flags.
  always_comb begin
    next_count_s = count_s;
    if (do_wr_s && !do_rd_s) begin
      next_count_s = count_s + PW'(1);
    end else if (!do_wr_s && do_rd_s) begin
      next_count_s = count_s - PW'(1);
    end else begin
      next_count_s = count_s;
    end
  end

  // FIFO pointers and registered level flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      present_r <= 1'b0;
      half_r    <= 1'b0;
      full_r    <= 1'b0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + PW'(do_wr_s);
      rd_ptr_r  <= rd_ptr_r + PW'(do_rd_s);
      present_r <= (next_count_s != '0);
      half_r    <= (next_count_s >= PW'(DEPTH / 2));
      full_r    <= (next_count_s == PW'(DEPTH));
    end
  end

  // Storage array; contents are only visible while present_r is set.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem[wr_ptr_r[AW-1:0]] <= push_data_r;
    end
  end

  assign head_s           = mem[rd_ptr_r[AW-1:0]];
  assign bus.rd_data      = present_r ? head_s[7:0] : 8'h00;
`ifdef PS2_RX_ERR_STORE_EN
  assign bus.rd_err       = present_r ? head_s[8] : 1'b0;
`else
  assign bus.rd_err       = 1'b0;
`endif
  assign bus.data_present = present_r;
  assign bus.data_half    = half_r;
  assign bus.data_full    = full_r;
  assign bus.err_parity   = flags_r[EV_PARITY];
  assign bus.err_frame    = flags_r[EV_FRAME];
  assign bus.err_timeout  = flags_r[EV_TIMEOUT];
  assign bus.err_overflow = flags_r[EV_OVERFLOW];
  assign bus.err_count    = err_count_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Randomised plus directed bench for ps2_rx_fifo against a frame-level queue model.
module tb_ps2_rx_fifo;

  localparam int DEPTH       = 4;
  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 500;
  localparam int CNT_W       = 3;
  localparam int HALF        = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_rx_fifo_if #(.CNT_W(CNT_W)) bus ();

  ps2_rx_fifo #(
    .DEPTH(DEPTH), .FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q[$];
  logic m_par, m_frm, m_to, m_ov;
  int   m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    q.delete();
    m_par = 1'b0; m_frm = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void m_err(input bit par, input bit frm, input bit to, input bit ov);
    m_par |= par; m_frm |= frm; m_to |= to; m_ov |= ov;
    if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
  endfunction

  function automatic void m_push(input logic [8:0] e);
    if (q.size() < DEPTH) q.push_back(e);
    else m_err(1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [8:0] head;
    head = (q.size() != 0) ? q[0] : 9'h000;
    check_eq({tag, ".rd_data"}, bus.rd_data, head[7:0]);
    check_eq({tag, ".rd_err"}, bus.rd_err, head[8]);
    check_eq({tag, ".present"}, bus.data_present, q.size() != 0);
    check_eq({tag, ".half"}, bus.data_half, q.size() >= DEPTH / 2);
    check_eq({tag, ".full"}, bus.data_full, q.size() == DEPTH);
    check_eq({tag, ".err_parity"}, bus.err_parity, m_par);
    check_eq({tag, ".err_frame"}, bus.err_frame, m_frm);
    check_eq({tag, ".err_timeout"}, bus.err_timeout, m_to);
    check_eq({tag, ".err_overflow"}, bus.err_overflow, m_ov);
    check_eq({tag, ".err_count"}, bus.err_count, m_cnt);
  endtask

  // Drives the first n bits (LSB first) of a frame; optionally times data_present after the last fall.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit measure);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (measure && (i == n - 1)) begin
        int lat;
        lat = 0;
        for (int c = 1; c <= HALF; c++) begin
          @(negedge clk);
          if (lat == 0 && bus.data_present) lat = c;
        end
        check_eq("latency", (lat != 0) && (lat <= FILT_LEN + 5), 1'b1);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit measure);
    send_bits(frame(b, bad_par, bad_stop), 11, measure);
    if (!bad_par && !bad_stop) begin
      m_push({1'b0, b});
    end else begin
      m_err(bad_par, bad_stop, 1'b0, 1'b0);
`ifdef PS2_RX_ERR_STORE_EN
      m_push({1'b1, b});
`endif
    end
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_errs();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    m_par = 1'b0; m_frm = 1'b0; m_to = 1'b0; m_ov = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] bits;
    bus.rd = 1'b0;
    bus.err_clr = 1'b0;
    m_reset();
    wait_cyc(3);
    check_all("reset");
    rst = 1'b0;
    wait_cyc(4);

    // Good byte, latency, single pop
    send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    check_all("t1");
    pop();
    check_all("t1_pop");

    // Bad parity, pop on empty, error clear
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    check_all("t2");
    pop();
    check_all("t2_rd_empty");
    clear_errs();
    check_all("t2_clr");

    // Fill to full and overflow
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b0, 1'b0, 1'b0);
      check_all("t3_fill");
    end
    for (int k = 0; k < DEPTH; k++) begin
      pop();
      check_all("t3_drain");
    end
    clear_errs();

    // Partial frame then timeout, then recovery
    send_bits(frame(8'h12, 1'b0, 1'b0), 4, 1'b0);
    wait_cyc(TIMEOUT_CYC + 10);
    m_err(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t4_timeout");
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    check_all("t4_after");
    pop();
    clear_errs();

    // Short glitch on ps2_clk while idle
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check_all("t5_glitch");

    // Eleven falls with data high in IDLE saturate the counter
    send_bits(11'h7FF, 11, 1'b0);
    for (int k = 0; k < 11; k++) m_err(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("t6_sat");
    clear_errs();

    // Reset mid-frame; trailing device bits are all ones
    bits = frame(8'hF0, 1'b0, 1'b0);
    send_bits(bits, 5, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    m_reset();
    check_all("t7_rst");
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
    send_bits(bits >> 5, 6, 1'b0);
    for (int k = 0; k < 6; k++) m_err(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("t7_tail");
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_all("t7_f0");
    pop();
    clear_errs();

    // Randomised frames, errors, reads and clears
    for (int n = 0; n < 40; n++) begin
      int r;
      int k;
      r = $urandom_range(0, 7);
      send_frame(8'($urandom), (r == 0) || (r == 2), (r == 1) || (r == 2), 1'b0);
      check_all("rnd");
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        pop();
        check_all("rnd_pop");
      end
      if ($urandom_range(0, 5) == 0) begin
        clear_errs();
        check_all("rnd_clr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
